// File: rtl/spi_resp_target_pkg.sv
// Shared types and constants for the SPI responder: FSM states, synchronizer
// depth and the default byte returned on MISO when no TX data is queued.
package spi_resp_target_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2
  } state_e;

  localparam int unsigned SYNC_STAGES       = 2;
  localparam logic [7:0]  FILL_BYTE_DEFAULT = 8'hFF;

endpackage

// File: rtl/spi_resp_fifo.sv
// Synchronous FIFO, power-of-two depth, pointers one bit wider than the address.
// A push while full succeeds when a pop happens in the same cycle.
module spi_resp_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  typedef logic [AW:0] ptr_t;

  ptr_t             wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok, push_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/spi_resp_target.sv
// SPI mode-0 responder with oversampled pins and valid/ready byte streams.
// Define SPI_RESP_RX_FIFO_EN to buffer received bytes in spi_resp_fifo.
module spi_resp_target
  import spi_resp_target_pkg::*;
#(
  parameter logic [7:0]  FILL_BYTE     = FILL_BYTE_DEFAULT,
  parameter int unsigned RX_FIFO_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       spi_clk_i,
  input  logic       spi_cs_i,
  input  logic       spi_mosi_i,
  output logic       spi_miso_o,
  output logic       spi_miso_oe_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  input  logic       rx_ready_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic       frame_start_o,
  output logic       frame_end_o,
  output logic       overrun_o,
  output logic       underrun_o
);

  // {sck, cs, mosi}; cleared on reset so a CS held low at reset release
  // produces no fall until it has been seen high.
  logic [2:0] sync_q [SYNC_STAGES];
  logic       sck_prev_q, cs_prev_q;
  logic       sck_s, cs_s, mosi_s;
  logic       sck_rise, sck_fall, cs_rise, cs_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      sck_prev_q <= 1'b0;
      cs_prev_q  <= 1'b0;
    end else begin
      sync_q[0] <= {spi_clk_i, spi_cs_i, spi_mosi_i};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sck_prev_q <= sync_q[SYNC_STAGES-1][2];
      cs_prev_q  <= sync_q[SYNC_STAGES-1][1];
    end
  end

  assign sck_s    = sync_q[SYNC_STAGES-1][2];
  assign cs_s     = sync_q[SYNC_STAGES-1][1];
  assign mosi_s   = sync_q[SYNC_STAGES-1][0];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign cs_rise  = cs_s & ~cs_prev_q;
  assign cs_fall  = ~cs_s & cs_prev_q;

  state_e     state_q;
  logic [2:0] bit_cnt_q;
  logic [7:0] rx_sr_q, tx_sr_q;
  logic       load_pend_q, miso_q, oe_q, fs_q, fe_q, ur_q, rx_done_q;
  logic [7:0] hold_q, hold_d, tx_next;
  logic       hold_full_q, hold_full_d, tx_accept, tx_load;

  // A CS rise wins over a coincident SCK fall, so no byte is loaded then.
  always_comb begin
    tx_load = 1'b0;
    if (!cs_rise) begin
      if (state_q == ST_LOAD) tx_load = 1'b1;
      else if (state_q == ST_SHIFT && sck_fall && load_pend_q) tx_load = 1'b1;
    end
  end

  assign tx_next   = hold_full_q ? hold_q : FILL_BYTE;
  assign tx_accept = tx_valid_i & ~hold_full_q;

  always_comb begin
    hold_d      = tx_accept ? tx_data_i : hold_q;
    hold_full_d = tx_accept | (hold_full_q & ~tx_load);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= '0;
      rx_sr_q     <= '0;
      tx_sr_q     <= '1;
      load_pend_q <= 1'b0;
      miso_q      <= 1'b1;
      oe_q        <= 1'b0;
      fs_q        <= 1'b0;
      fe_q        <= 1'b0;
      ur_q        <= 1'b0;
      rx_done_q   <= 1'b0;
    end else begin
      fs_q      <= 1'b0;
      fe_q      <= 1'b0;
      rx_done_q <= 1'b0;
      ur_q      <= tx_load & ~hold_full_q;
      miso_q    <= (state_q == ST_IDLE) ? 1'b1 : tx_sr_q[7];
      case (state_q)
        ST_LOAD, ST_SHIFT: begin
          if (cs_rise) begin
            state_q     <= ST_IDLE;
            fe_q        <= 1'b1;
            oe_q        <= 1'b0;
            bit_cnt_q   <= '0;
            rx_sr_q     <= '0;
            tx_sr_q     <= '1;
            load_pend_q <= 1'b0;
          end else if (state_q == ST_LOAD) begin
            state_q     <= ST_SHIFT;
            tx_sr_q     <= tx_next;
            bit_cnt_q   <= '0;
            load_pend_q <= 1'b0;
          end else if (sck_rise) begin
            rx_sr_q   <= {rx_sr_q[6:0], mosi_s};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              rx_done_q   <= 1'b1;
              load_pend_q <= 1'b1;
            end
          end else if (sck_fall) begin
            if (load_pend_q) begin
              tx_sr_q     <= tx_next;
              load_pend_q <= 1'b0;
            end else begin
              tx_sr_q <= {tx_sr_q[6:0], 1'b1};
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          if (cs_fall) begin
            state_q <= ST_LOAD;
            fs_q    <= 1'b1;
            oe_q    <= 1'b1;
          end
        end
      endcase
    end
  end

  assign spi_miso_o    = miso_q;
  assign spi_miso_oe_o = oe_q;
  assign tx_ready_o    = ~hold_full_q;
  assign frame_start_o = fs_q;
  assign frame_end_o   = fe_q;
  assign underrun_o    = ur_q;

  // rx_sr_q stays stable for several cycles after rx_done_q, so it feeds RX directly.
  logic ov_q;
  assign overrun_o = ov_q;

`ifdef SPI_RESP_RX_FIFO_EN
  logic rx_full, rx_empty, rx_pop;

  assign rx_pop     = rx_ready_i & ~rx_empty;
  assign rx_valid_o = ~rx_empty;

  spi_resp_fifo #(
    .DEPTH (RX_FIFO_DEPTH),
    .WIDTH (8)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (rx_done_q),
    .data_i  (rx_sr_q),
    .pop_i   (rx_pop),
    .data_o  (rx_data_o),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) ov_q <= 1'b0;
    else       ov_q <= rx_done_q & rx_full & ~rx_pop;
  end
`else
  logic       rx_valid_q;
  logic [7:0] rx_data_q;
  logic       unused_fifo_depth;

  assign unused_fifo_depth = (RX_FIFO_DEPTH != 0);
  assign rx_valid_o        = rx_valid_q;
  assign rx_data_o         = rx_data_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      ov_q       <= 1'b0;
    end else begin
      ov_q <= 1'b0;
      if (rx_done_q) begin
        rx_data_q  <= rx_sr_q;
        rx_valid_q <= 1'b1;
        ov_q       <= rx_valid_q & ~rx_ready_i;
      end else if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_spi_resp_target.sv
// Bench for spi_resp_target: bench acts as SPI host; RX bytes and MISO bytes are
// checked against queues of expected values, pulses are counted per test.
module tb_spi_resp_target;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_i, spi_clk_i, spi_cs_i, spi_mosi_i;
  logic       spi_miso_o, spi_miso_oe_o;
  logic [7:0] rx_data_o, tx_data_i;
  logic       rx_valid_o, rx_ready_i, tx_valid_i, tx_ready_o;
  logic       frame_start_o, frame_end_o, overrun_o, underrun_o;

  int checks = 0;
  int errors = 0;
  int n_fs, n_fe, n_ur, n_ov;
  logic [7:0] exp_rx_q[$], exp_miso_q[$], tx_q[$], mo_q[$];

  always #10 clk = ~clk;

  spi_resp_target dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .spi_clk_i     (spi_clk_i),
    .spi_cs_i      (spi_cs_i),
    .spi_mosi_i    (spi_mosi_i),
    .spi_miso_o    (spi_miso_o),
    .spi_miso_oe_o (spi_miso_oe_o),
    .rx_data_o     (rx_data_o),
    .rx_valid_o    (rx_valid_o),
    .rx_ready_i    (rx_ready_i),
    .tx_data_i     (tx_data_i),
    .tx_valid_i    (tx_valid_i),
    .tx_ready_o    (tx_ready_o),
    .frame_start_o (frame_start_o),
    .frame_end_o   (frame_end_o),
    .overrun_o     (overrun_o),
    .underrun_o    (underrun_o)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: pulse counters and RX scoreboard, sampled mid-cycle.
  always begin
    @(negedge clk);
    #1;
    n_fs += int'(frame_start_o);
    n_fe += int'(frame_end_o);
    n_ur += int'(underrun_o);
    n_ov += int'(overrun_o);
    if (rx_valid_o && rx_ready_i) begin
      if (exp_rx_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected: got %0h, expected none", rx_data_o);
      end else begin
        check("rx_data", rx_data_o, exp_rx_q.pop_front());
      end
    end
  end

  // TX feeder: presents queued bytes, retires one per accepted handshake.
  initial begin
    bit acc_pend = 1'b0;
    tx_valid_i = 1'b0;
    tx_data_i  = '0;
    forever begin
      @(negedge clk);
      if (acc_pend) void'(tx_q.pop_front());
      tx_valid_i = (tx_q.size() > 0);
      tx_data_i  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
      #1;
      acc_pend = tx_valid_i && tx_ready_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic clear_counts();
    n_fs = 0; n_fe = 0; n_ur = 0; n_ov = 0;
  endtask

  task automatic check_counts(input string t, input int fs, input int fe, input int ur, input int ov);
    check({t, "_frame_start"}, n_fs, fs);
    check({t, "_frame_end"},   n_fe, fe);
    check({t, "_underrun"},    n_ur, ur);
    check({t, "_overrun"},     n_ov, ov);
    check({t, "_rx_drained"},  exp_rx_q.size(), 0);
  endtask

  task automatic spi_byte(input logic [7:0] mo, input bit last, output logic [7:0] mi);
    for (int i = 7; i >= 0; i--) begin
      spi_mosi_i = mo[i];
      tick(HALF);
      spi_clk_i = 1'b1;
      mi[i] = spi_miso_o;
      tick(HALF);
      if (!(last && i == 0)) spi_clk_i = 1'b0;
    end
  endtask

  // Final SCK fall and CS rise are driven together.
  task automatic run_frame();
    logic [7:0] mi;
    int n = mo_q.size();
    spi_cs_i = 1'b0;
    tick(8);
    for (int k = 0; k < n; k++) begin
      spi_byte(mo_q[k], k == n - 1, mi);
      if (exp_miso_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL miso_unexpected: got %0h, expected none", mi);
      end else begin
        check("miso_byte", mi, exp_miso_q.pop_front());
      end
    end
    spi_clk_i = 1'b0;
    spi_cs_i  = 1'b1;
    tick(12);
    mo_q.delete();
  endtask

  task automatic check_reset_outputs(input string t);
    check({t, "_miso"},       spi_miso_o, 1);
    check({t, "_miso_oe"},    spi_miso_oe_o, 0);
    check({t, "_rx_valid"},   rx_valid_o, 0);
    check({t, "_rx_data"},    rx_data_o, 0);
    check({t, "_tx_ready"},   tx_ready_o, 1);
    check({t, "_pulses"},     {frame_start_o, frame_end_o, overrun_o, underrun_o}, 0);
  endtask

  initial begin
    logic [7:0] tmp;
    rst_i = 1'b1; spi_clk_i = 1'b0; spi_cs_i = 1'b1; spi_mosi_i = 1'b0; rx_ready_i = 1'b1;
    clear_counts();
    tick(3);
    #2;
    check_reset_outputs("reset");
    rst_i = 1'b0;
    tick(6);

    // One byte, TX preloaded
    clear_counts();
    tx_q.push_back(8'h3C);
    tick(6);
    check("t1_tx_ready_full", tx_ready_o, 0);
    mo_q = '{8'hA5};
    exp_rx_q.push_back(8'hA5);
    exp_miso_q.push_back(8'h3C);
    run_frame();
    check_counts("t1", 1, 1, 0, 0);

    // Three bytes, no TX data
    clear_counts();
    mo_q = '{8'h10, 8'h20, 8'h30};
    exp_rx_q = '{8'h10, 8'h20, 8'h30};
    exp_miso_q = '{8'hFF, 8'hFF, 8'hFF};
    run_frame();
    check_counts("t2", 1, 1, 3, 0);

    // CS raised after 5 bits, then a clean byte
    clear_counts();
    spi_cs_i = 1'b0;
    tick(8);
    for (int i = 0; i < 5; i++) begin
      spi_mosi_i = 1'b1;
      tick(HALF); spi_clk_i = 1'b1;
      tick(HALF); spi_clk_i = 1'b0;
    end
    tick(HALF);
    spi_cs_i = 1'b1;
    tick(12);
    check("t3_partial_no_rx", rx_valid_o, 0);
    mo_q = '{8'h81};
    exp_rx_q.push_back(8'h81);
    exp_miso_q.push_back(8'hFF);
    run_frame();
    check_counts("t3", 2, 2, 2, 0);

    // RX held off
    clear_counts();
    rx_ready_i = 1'b0;
`ifdef SPI_RESP_RX_FIFO_EN
    for (int i = 1; i <= 9; i++) begin
      tmp = 8'(i);
      mo_q.push_back(tmp);
      exp_miso_q.push_back(8'hFF);
      if (i <= 8) exp_rx_q.push_back(tmp);
    end
    run_frame();
    check("t4_head", rx_data_o, 8'h01);
    check("t4_valid", rx_valid_o, 1);
    rx_ready_i = 1'b1;
    tick(12);
    check_counts("t4", 1, 1, 9, 1);
`else
    mo_q = '{8'h01, 8'h02};
    exp_miso_q = '{8'hFF, 8'hFF};
    exp_rx_q.push_back(8'h02);
    run_frame();
    check("t4_data", rx_data_o, 8'h02);
    check("t4_valid", rx_valid_o, 1);
    rx_ready_i = 1'b1;
    tick(4);
    check_counts("t4", 1, 1, 2, 1);
`endif

    // One-cycle reset mid-byte, then a fresh frame
    clear_counts();
    spi_cs_i = 1'b0;
    tick(8);
    for (int i = 0; i < 3; i++) begin
      spi_mosi_i = 1'b1;
      tick(HALF); spi_clk_i = 1'b1;
      tick(HALF); spi_clk_i = 1'b0;
    end
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    #2;
    check_reset_outputs("t5_rst");
    tick(4);
    check("t5_oe_cs_low", spi_miso_oe_o, 0);
    spi_cs_i = 1'b1;
    tick(10);
    tx_q.push_back(8'h5A);
    tick(6);
    mo_q = '{8'h5A};
    exp_rx_q.push_back(8'h5A);
    exp_miso_q.push_back(8'h5A);
    run_frame();
    check_counts("t5", 2, 1, 1, 0);

    // Back-to-back TX stream
    clear_counts();
    tx_q = '{8'h11, 8'h22, 8'h33};
    tick(6);
    mo_q = '{8'hC1, 8'hC2, 8'hC3};
    exp_rx_q = '{8'hC1, 8'hC2, 8'hC3};
    exp_miso_q = '{8'h11, 8'h22, 8'h33};
    run_frame();
    check_counts("t6", 1, 1, 0, 0);
    check("t6_tx_ready", tx_ready_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
